crc_stream_engine: RTL and testbench

Parametrised, beat-parallel CRC engine for framed streams; the next generation of the team's serial 8-bit CRC generator. Accepts DATA_W-bit beats under valid/ready, passes them through one output register stage, and appends the frame's CRC (MSB-first) as extra beats after the last input beat. Sits between a framing source and a serialiser/link; the final CRC is also exposed on a side port.

---
 rtl/crc_stream_pkg.sv | 20 ++
 rtl/crc_stream_engine_step.sv | 26 ++
 rtl/crc_stream_engine.sv | 164 ++++++++++++++++
 tb/tb_crc_stream_engine.sv | 377 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/crc_stream_pkg.sv
// crc_stream_pkg: shared types and helpers for the CRC stream engine.
// State encoding, beats-per-CRC helper and parameter legality check.
package crc_stream_pkg;

    typedef enum logic {
        ST_PASS   = 1'b0,
        ST_APPEND = 1'b1
    } state_e;

    // Number of DATA_W-bit beats needed to carry one CRC.
    function automatic int crc_nb(input int crc_w, input int data_w);
        return crc_w / data_w;
    endfunction

    // The CRC must split into a whole number of beats.
    function automatic bit params_ok(input int crc_w, input int data_w);
        return (data_w > 0) && (crc_w >= data_w) && ((crc_w % data_w) == 0);
    endfunction

endpackage

// File: rtl/crc_stream_engine_step.sv
// crc_step: combinational one-beat CRC update, data bits MSB-first.
// Non-reflected polynomial with the implicit top bit omitted.
module crc_step #(
    parameter int             CRC_W  = 8,
    parameter int             DATA_W = 8,
    parameter logic [CRC_W-1:0] POLY = 8'h07
) (
    input  logic [CRC_W-1:0]  crc_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [CRC_W-1:0]  crc_o
);

    // Bit-serial LFSR recurrence unrolled across the whole beat.
    always_comb begin
        logic [CRC_W-1:0] c;
        logic             fb;
        c  = crc_i;
        fb = 1'b0;
        for (int i = DATA_W - 1; i >= 0; i--) begin
            fb = c[CRC_W-1] ^ data_i[i];
            c  = (c << 1) ^ (fb ? POLY : '0);
        end
        crc_o = c;
    end

endmodule

// File: rtl/crc_stream_engine.sv
// crc_stream_engine: beat-parallel CRC for framed streams, CRC appended MSB-first.
// Optional check mode (pass-through + residue compare): CRC_STREAM_ENGINE_CHECK_EN.
module crc_stream_engine
    import crc_stream_pkg::*;
#(
    parameter int               CRC_W   = 8,
    parameter int               DATA_W  = 8,
    parameter logic [CRC_W-1:0] POLY    = 8'h07,
    parameter logic [CRC_W-1:0] INIT    = '0,
    parameter logic [CRC_W-1:0] XOROUT  = '0,
    parameter logic [CRC_W-1:0] RESIDUE = '0
) (
    input  logic              clk,
    input  logic              rst,
`ifdef CRC_STREAM_ENGINE_CHECK_EN
    input  logic              check_mode,
    output logic              crc_err,
    output logic              crc_err_valid,
`endif
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_last,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    output logic [CRC_W-1:0]  crc_out,
    output logic              crc_valid
);

    localparam int NB = crc_nb(CRC_W, DATA_W);
    localparam int CW = $clog2(NB) + 1;

    if (!params_ok(CRC_W, DATA_W)) begin : g_bad_params
        $error("crc_stream_engine: CRC_W must be a multiple of DATA_W");
    end

    state_e              state_q;
    logic [CRC_W-1:0]    crc_q;
    logic [CW-1:0]       cnt_q;
    logic                m_valid_q;
    logic [DATA_W-1:0]   m_data_q;
    logic                m_last_q;
    logic [CRC_W-1:0]    crc_out_q;
    logic                crc_valid_q;

    logic [CRC_W-1:0]    crc_d;
    logic [CRC_W-1:0]    slice_sh;
    logic [DATA_W-1:0]   slice;
    logic                out_free;
    logic                accept;
    logic                last_slice;
    logic                chk_mode;

    crc_step #(
        .CRC_W  (CRC_W),
        .DATA_W (DATA_W),
        .POLY   (POLY)
    ) u_step (
        .crc_i  (crc_q),
        .data_i (s_data),
        .crc_o  (crc_d)
    );

    assign out_free   = ~m_valid_q | m_ready;
    assign s_ready    = (state_q == ST_PASS) & out_free;
    assign accept     = s_valid & s_ready;
    assign last_slice = (cnt_q == CW'(NB - 1));
    assign slice_sh   = crc_out_q >> (DATA_W * (NB - 1 - int'(cnt_q)));
    assign slice      = slice_sh[DATA_W-1:0];

`ifdef CRC_STREAM_ENGINE_CHECK_EN
    logic mode_q;
    logic in_frame_q;
    logic crc_err_q;
    logic crc_err_valid_q;

    // Mode is taken from the port on a frame's first beat, then held.
    assign chk_mode = in_frame_q ? mode_q : check_mode;

    // Frame tracking and residue comparison on the closing beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q          <= 1'b0;
            in_frame_q      <= 1'b0;
            crc_err_q       <= 1'b0;
            crc_err_valid_q <= 1'b0;
        end else begin
            crc_err_valid_q <= 1'b0;
            if (accept) begin
                mode_q     <= chk_mode;
                in_frame_q <= ~s_last;
                if (s_last) begin
                    crc_err_q       <= (crc_d != RESIDUE);
                    crc_err_valid_q <= 1'b1;
                end
            end
        end
    end

    assign crc_err       = crc_err_q;
    assign crc_err_valid = crc_err_valid_q;
`else
    assign chk_mode = 1'b0;
`endif

    // Main FSM: pass beats through, then append CRC slices MSB-first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_PASS;
            crc_q       <= INIT;
            cnt_q       <= '0;
            m_valid_q   <= 1'b0;
            m_data_q    <= '0;
            m_last_q    <= 1'b0;
            crc_out_q   <= '0;
            crc_valid_q <= 1'b0;
        end else begin
            crc_valid_q <= 1'b0;
            if (m_valid_q && m_ready) begin
                m_valid_q <= 1'b0;
            end
            unique case (state_q)
                ST_PASS: begin
                    if (accept) begin
                        m_valid_q <= 1'b1;
                        m_data_q  <= s_data;
                        m_last_q  <= s_last & chk_mode;
                        if (s_last) begin
                            crc_out_q   <= crc_d ^ XOROUT;
                            crc_valid_q <= 1'b1;
                            crc_q       <= INIT;
                            cnt_q       <= '0;
                            state_q     <= chk_mode ? ST_PASS : ST_APPEND;
                        end else begin
                            crc_q <= crc_d;
                        end
                    end
                end
                ST_APPEND: begin
                    if (out_free) begin
                        m_valid_q <= 1'b1;
                        m_data_q  <= slice;
                        m_last_q  <= last_slice;
                        if (last_slice) begin
                            cnt_q   <= '0;
                            state_q <= ST_PASS;
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                end
            endcase
        end
    end

    assign m_valid   = m_valid_q;
    assign m_data    = m_data_q;
    assign m_last    = m_last_q;
    assign crc_out   = crc_out_q;
    assign crc_valid = crc_valid_q;

endmodule

// File: tb/tb_crc_stream_engine.sv
// tb_crc_stream_engine: directed tests for CRC-8 and CRC-16 builds of the engine.
// Check-mode tests run only when CRC_STREAM_ENGINE_CHECK_EN is defined.
module tb_crc_stream_engine;

    logic clk = 1'b0;
    logic rst;
    logic sel;
    logic s_valid, s_last, m_ready;
    logic [7:0] s_data;
`ifdef CRC_STREAM_ENGINE_CHECK_EN
    logic check_mode;
    logic crc_err8, crc_err_valid8, crc_err16, crc_err_valid16;
`endif

    logic s_valid8, s_ready8, m_valid8, m_last8, crc_valid8;
    logic [7:0] m_data8, crc_out8;
    logic s_valid16, s_ready16, m_valid16, m_last16, crc_valid16;
    logic [7:0] m_data16;
    logic [15:0] crc_out16;

    logic s_ready_v, m_valid_v, m_last_v, crc_valid_v;
    logic [7:0] m_data_v;
    logic [15:0] crc_out_v;

    int checks = 0;
    int errors = 0;

    logic [7:0] tx [16];
    logic [7:0] rx_d [32];
    logic       rx_l [32];
    int rx_n, stall_viol, sready_viol, gaps, cv_cnt, cv_cyc, acc_cyc;
    logic [15:0] cv_val;
    logic timeout;
    logic err_seen, errv_seen;

    always #5 clk = ~clk;

    assign s_valid8    = s_valid & ~sel;
    assign s_valid16   = s_valid & sel;
    assign s_ready_v   = sel ? s_ready16 : s_ready8;
    assign m_valid_v   = sel ? m_valid16 : m_valid8;
    assign m_last_v    = sel ? m_last16 : m_last8;
    assign m_data_v    = sel ? m_data16 : m_data8;
    assign crc_valid_v = sel ? crc_valid16 : crc_valid8;
    assign crc_out_v   = sel ? crc_out16 : {8'h00, crc_out8};

    crc_stream_engine u_dut8 (
        .clk           (clk),
        .rst           (rst),
`ifdef CRC_STREAM_ENGINE_CHECK_EN
        .check_mode    (check_mode),
        .crc_err       (crc_err8),
        .crc_err_valid (crc_err_valid8),
`endif
        .s_valid       (s_valid8),
        .s_ready       (s_ready8),
        .s_data        (s_data),
        .s_last        (s_last),
        .m_valid       (m_valid8),
        .m_ready       (m_ready),
        .m_data        (m_data8),
        .m_last        (m_last8),
        .crc_out       (crc_out8),
        .crc_valid     (crc_valid8)
    );

    crc_stream_engine #(
        .CRC_W  (16),
        .DATA_W (8),
        .POLY   (16'h1021),
        .INIT   (16'hFFFF)
    ) u_dut16 (
        .clk           (clk),
        .rst           (rst),
`ifdef CRC_STREAM_ENGINE_CHECK_EN
        .check_mode    (1'b0),
        .crc_err       (crc_err16),
        .crc_err_valid (crc_err_valid16),
`endif
        .s_valid       (s_valid16),
        .s_ready       (s_ready16),
        .s_data        (s_data),
        .s_last        (s_last),
        .m_valid       (m_valid16),
        .m_ready       (m_ready),
        .m_data        (m_data16),
        .m_last        (m_last16),
        .crc_out       (crc_out16),
        .crc_valid     (crc_valid16)
    );

    // Drive one frame from tx[0..n-1] and record what comes out.
    task automatic run_frame(input int n, input bit rnd);
        int idx = 0;
        int cyc = 0;
        bit after_last = 0;
        bit seen_last = 0;
        bit stalled = 0;
        bit started = 0;
        logic [7:0] hd = '0;
        logic hl = 1'b0;
        rx_n = 0; stall_viol = 0; sready_viol = 0; gaps = 0;
        cv_cnt = 0; cv_cyc = -1; acc_cyc = -1; cv_val = '0;
        err_seen = 1'b0; errv_seen = 1'b0;
        while (!seen_last && cyc < 300) begin
            @(posedge clk); #1;
            s_valid = (idx < n);
            s_data  = (idx < n) ? tx[idx] : 8'h00;
            s_last  = (idx == n - 1);
            m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            cyc++;
            if (stalled && (m_data_v !== hd || m_last_v !== hl || m_valid_v !== 1'b1))
                stall_viol++;
            if (crc_valid_v === 1'b1) begin
                cv_cnt++;
                cv_cyc = cyc;
                cv_val = crc_out_v;
            end
`ifdef CRC_STREAM_ENGINE_CHECK_EN
            if (crc_err_valid8 === 1'b1 && !sel) begin
                errv_seen = 1'b1;
                err_seen  = crc_err8;
            end
`endif
            if (after_last && !(m_valid_v && m_last_v) && s_ready_v !== 1'b0)
                sready_viol++;
            if (started && m_valid_v !== 1'b1) gaps++;
            if (m_valid_v === 1'b1) started = 1;
            if (s_valid && s_ready_v) begin
                if (s_last) begin
                    after_last = 1;
                    acc_cyc = cyc;
                end
                idx++;
            end
            if (m_valid_v && m_ready && rx_n < 32) begin
                rx_d[rx_n] = m_data_v;
                rx_l[rx_n] = m_last_v;
                rx_n++;
                if (m_last_v) seen_last = 1;
            end
            stalled = m_valid_v && !m_ready;
            hd = m_data_v;
            hl = m_last_v;
        end
        timeout = !seen_last;
        @(posedge clk); #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
        m_ready = 1'b1;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({s_ready8, m_valid8, m_last8, crc_valid8, m_data8, crc_out8} !== 20'h80000) begin
            errors++;
            $display("FAIL reset_in8: got %h expected %h",
                     {s_ready8, m_valid8, m_last8, crc_valid8, m_data8, crc_out8}, 20'h80000);
        end
        checks++;
        if ({s_ready16, m_valid16, m_last16, crc_valid16, m_data16, crc_out16} !== 28'h8000000) begin
            errors++;
            $display("FAIL reset_in16: got %h expected %h",
                     {s_ready16, m_valid16, m_last16, crc_valid16, m_data16, crc_out16}, 28'h8000000);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({s_ready8, m_valid8, crc_valid8} !== 3'b100) begin
            errors++;
            $display("FAIL reset_after: got %b expected %b", {s_ready8, m_valid8, crc_valid8}, 3'b100);
        end
    endtask

    task automatic test_single_beat();
        sel = 1'b0;
        tx[0] = 8'hB3;
        run_frame(1, 1'b0);
        checks++;
        if (timeout !== 1'b0 || rx_n !== 2) begin
            errors++;
            $display("FAIL single_count: got %0d beats (timeout %b) expected 2", rx_n, timeout);
        end
        checks++;
        if ({rx_d[0], rx_l[0], rx_d[1], rx_l[1]} !== {8'hB3, 1'b0, 8'h10, 1'b1}) begin
            errors++;
            $display("FAIL single_beats: got %h/%b %h/%b expected b3/0 10/1",
                     rx_d[0], rx_l[0], rx_d[1], rx_l[1]);
        end
        checks++;
        if (cv_cnt !== 1 || cv_val !== 16'h0010) begin
            errors++;
            $display("FAIL single_crc: got %h (%0d pulses) expected 0010 (1 pulse)", cv_val, cv_cnt);
        end
        checks++;
        if (cv_cyc !== acc_cyc + 1) begin
            errors++;
            $display("FAIL single_crc_timing: got cycle %0d expected %0d", cv_cyc, acc_cyc + 1);
        end
        checks++;
        if (gaps !== 0 || sready_viol !== 0) begin
            errors++;
            $display("FAIL single_flow: got gaps %0d sready %0d expected 0 0", gaps, sready_viol);
        end
        checks++;
        if (crc_out8 !== 8'h10 || crc_valid8 !== 1'b0) begin
            errors++;
            $display("FAIL single_hold: got %h/%b expected 10/0", crc_out8, crc_valid8);
        end
    endtask

    task automatic test_back_to_back();
        sel = 1'b0;
        tx[0] = 8'h01;
        tx[1] = 8'h02;
        run_frame(2, 1'b0);
        checks++;
        if (timeout !== 1'b0 || rx_n !== 3) begin
            errors++;
            $display("FAIL b2b_count: got %0d beats expected 3", rx_n);
        end
        checks++;
        if ({rx_d[0], rx_d[1], rx_d[2]} !== 24'h01021B ||
            {rx_l[0], rx_l[1], rx_l[2]} !== 3'b001) begin
            errors++;
            $display("FAIL b2b_beats: got %h %h %h last %b%b%b expected 01 02 1b last 001",
                     rx_d[0], rx_d[1], rx_d[2], rx_l[0], rx_l[1], rx_l[2]);
        end
        checks++;
        if (cv_val !== 16'h001B || gaps !== 0) begin
            errors++;
            $display("FAIL b2b_crc: got %h gaps %0d expected 001b gaps 0", cv_val, gaps);
        end
    endtask

    task automatic test_crc16();
        sel = 1'b1;
        for (int i = 0; i < 9; i++) tx[i] = 8'h31 + 8'(i);
        run_frame(9, 1'b0);
        checks++;
        if (timeout !== 1'b0 || rx_n !== 11) begin
            errors++;
            $display("FAIL crc16_count: got %0d beats expected 11", rx_n);
        end
        checks++;
        if ({rx_d[0], rx_d[8], rx_d[9], rx_d[10]} !== 32'h3139_29B1 ||
            {rx_l[8], rx_l[9], rx_l[10]} !== 3'b001) begin
            errors++;
            $display("FAIL crc16_beats: got %h %h %h %h last %b%b%b expected 31 39 29 b1 last 001",
                     rx_d[0], rx_d[8], rx_d[9], rx_d[10], rx_l[8], rx_l[9], rx_l[10]);
        end
        checks++;
        if (cv_val !== 16'h29B1 || cv_cnt !== 1 || gaps !== 0 || sready_viol !== 0) begin
            errors++;
            $display("FAIL crc16_crc: got %h pulses %0d gaps %0d sready %0d expected 29b1 1 0 0",
                     cv_val, cv_cnt, gaps, sready_viol);
        end
        sel = 1'b0;
    endtask

    task automatic test_backpressure();
        sel = 1'b0;
        for (int r = 0; r < 4; r++) begin
            tx[0] = 8'hB3;
            run_frame(1, 1'b1);
            checks++;
            if (timeout !== 1'b0 || rx_n !== 2 ||
                {rx_d[0], rx_l[0], rx_d[1], rx_l[1]} !== {8'hB3, 1'b0, 8'h10, 1'b1}) begin
                errors++;
                $display("FAIL bp_beats[%0d]: got n=%0d %h/%b %h/%b expected 2 b3/0 10/1",
                         r, rx_n, rx_d[0], rx_l[0], rx_d[1], rx_l[1]);
            end
            checks++;
            if (stall_viol !== 0 || sready_viol !== 0) begin
                errors++;
                $display("FAIL bp_stable[%0d]: got stall %0d sready %0d expected 0 0",
                         r, stall_viol, sready_viol);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        sel = 1'b0;
        @(posedge clk); #1;
        s_valid = 1'b1;
        s_data  = 8'hAA;
        s_last  = 1'b0;
        m_ready = 1'b0;
        @(posedge clk); #1;
        s_valid = 1'b0;
        checks++;
        if (m_valid8 !== 1'b1 || m_data8 !== 8'hAA) begin
            errors++;
            $display("FAIL midrst_pre: got %b/%h expected 1/aa", m_valid8, m_data8);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({s_ready8, m_valid8, m_last8, crc_valid8, m_data8} !== 12'h800) begin
            errors++;
            $display("FAIL midrst_out: got %h expected 800",
                     {s_ready8, m_valid8, m_last8, crc_valid8, m_data8});
        end
        @(posedge clk); #1;
        rst = 1'b0;
        m_ready = 1'b1;
        tx[0] = 8'hB3;
        run_frame(1, 1'b0);
        checks++;
        if (timeout !== 1'b0 || rx_n !== 2 || rx_d[1] !== 8'h10 || cv_val !== 16'h0010) begin
            errors++;
            $display("FAIL midrst_after: got n=%0d crc beat %h crc %h expected 2 10 0010",
                     rx_n, rx_d[1], cv_val);
        end
    endtask

`ifdef CRC_STREAM_ENGINE_CHECK_EN
    task automatic test_check_mode();
        sel = 1'b0;
        check_mode = 1'b1;
        tx[0] = 8'hB3;
        tx[1] = 8'h10;
        run_frame(2, 1'b0);
        checks++;
        if (timeout !== 1'b0 || rx_n !== 2 || {rx_d[1], rx_l[1]} !== {8'h10, 1'b1} || rx_l[0] !== 1'b0) begin
            errors++;
            $display("FAIL chk_good_beats: got n=%0d %h/%b expected 2 10/1", rx_n, rx_d[1], rx_l[1]);
        end
        checks++;
        if (errv_seen !== 1'b1 || err_seen !== 1'b0) begin
            errors++;
            $display("FAIL chk_good_err: got valid %b err %b expected 1 0", errv_seen, err_seen);
        end
        tx[1] = 8'h11;
        run_frame(2, 1'b0);
        checks++;
        if (timeout !== 1'b0 || rx_n !== 2 || {rx_d[1], rx_l[1]} !== {8'h11, 1'b1}) begin
            errors++;
            $display("FAIL chk_bad_beats: got n=%0d %h/%b expected 2 11/1", rx_n, rx_d[1], rx_l[1]);
        end
        checks++;
        if (errv_seen !== 1'b1 || err_seen !== 1'b1 || cv_val !== 16'h0007) begin
            errors++;
            $display("FAIL chk_bad_err: got valid %b err %b crc %h expected 1 1 0007",
                     errv_seen, err_seen, cv_val);
        end
        check_mode = 1'b0;
    endtask
`endif

    initial begin
        rst = 1'b1;
        sel = 1'b0;
        s_valid = 1'b0;
        s_data = 8'h00;
        s_last = 1'b0;
        m_ready = 1'b1;
`ifdef CRC_STREAM_ENGINE_CHECK_EN
        check_mode = 1'b0;
`endif
        test_reset();
        test_single_beat();
        test_back_to_back();
        test_crc16();
        test_backpressure();
        test_reset_mid_frame();
`ifdef CRC_STREAM_ENGINE_CHECK_EN
        test_check_mode();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
